// File: rtl/sccb_master_if.sv
// Request/response and SCCB line bundle shared by the SCCB master and whoever drives it.
// The master modport is the controller side; the slave modport is the requester and pad side.
interface sccb_master_if;
  logic       sccb_valid;
  logic       sccb_ready;
  logic [3:0] sccb_op_type;
  logic [6:0] sccb_addr;
  logic [7:0] sccb_REG;
  logic [7:0] sccb_DATA_IN;
  logic [7:0] sccb_DATA_OUT;
  logic       SIO_C;
  logic       sio_d_out;
  logic       sio_d_oe;
  logic       sio_d_in;

  modport master (
    input  sccb_valid, sccb_op_type, sccb_addr, sccb_REG, sccb_DATA_IN, sio_d_in,
    output sccb_ready, sccb_DATA_OUT, SIO_C, sio_d_out, sio_d_oe
  );

  modport slave (
    output sccb_valid, sccb_op_type, sccb_addr, sccb_REG, sccb_DATA_IN, sio_d_in,
    input  sccb_ready, sccb_DATA_OUT, SIO_C, sio_d_out, sio_d_oe
  );
endinterface

// File: rtl/sccb_master.sv
// SCCB (I2C-like) master: runs 3-phase writes, 2-phase writes and 2-phase reads.
// Every bus event lives in a slot of four quarters, each CLK_DIV clocks long.
module sccb_master #(
  parameter int CLK_DIV = 125
) (
  input  logic          clk,
  input  logic          rst,
  sccb_master_if.master bus
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} state_t;

  state_t        r_state, w_state;
  logic [QW-1:0] r_qcnt, w_qcnt;
  logic [1:0]    r_quarter, w_quarter;
  logic [3:0]    r_bit, w_bit;
  logic [1:0]    r_byte, w_byte;
  logic [3:0]    r_op, w_op;
  logic [6:0]    r_addr, w_addr;
  logic [7:0]    r_reg, w_reg;
  logic [7:0]    r_data, w_data;
  logic [7:0]    r_rx, w_rx;
  logic [7:0]    r_dataOut, w_dataOut;
  logic          r_ready, w_ready;

  logic          w_qEnd, w_slotEnd, w_readPhase, w_bitVal;
  logic [1:0]    w_lastByte;
  logic [7:0]    w_curByte;
  logic          w_scl, w_sdaOut, w_sdaOe;

  assign w_qEnd      = (r_qcnt == Q_LAST);
  assign w_slotEnd   = w_qEnd && (r_quarter == 2'd3);
  assign w_lastByte  = (r_op == 4'd0) ? 2'd2 : 2'd1;
  assign w_readPhase = (r_op == 4'd2) && (r_byte == 2'd1);

  always_comb begin
    case (r_byte)
      2'd0:    w_curByte = {r_addr, r_op == 4'd2};
      2'd1:    w_curByte = r_reg;
      default: w_curByte = r_data;
    endcase
  end

  assign w_bitVal = r_bit[3] ? 1'b1 : w_curByte[3'd7 - r_bit[2:0]];

  always_comb begin
    w_state   = r_state;
    w_qcnt    = r_qcnt;
    w_quarter = r_quarter;
    w_bit     = r_bit;
    w_byte    = r_byte;
    w_op      = r_op;
    w_addr    = r_addr;
    w_reg     = r_reg;
    w_data    = r_data;
    w_rx      = r_rx;
    w_dataOut = r_dataOut;
    w_ready   = r_ready;
    case (r_state)
      IDLE: begin
        if (bus.sccb_valid) begin
          w_op      = bus.sccb_op_type;
          w_addr    = bus.sccb_addr;
          w_reg     = bus.sccb_REG;
          w_data    = bus.sccb_DATA_IN;
          w_qcnt    = '0;
          w_quarter = 2'd0;
          w_bit     = 4'd0;
          w_byte    = 2'd0;
          if (bus.sccb_op_type < 4'd3) begin
            w_state = START;
          end else begin
            w_state = DONE;
            w_ready = 1'b1;
          end
        end
      end
      START, BITS, STOP: begin
        if (w_qEnd) begin
          w_qcnt    = '0;
          w_quarter = r_quarter + 2'd1;
        end else begin
          w_qcnt = r_qcnt + QW'(1);
        end
        // Slave data is sampled on the first clock of Q3, well after SCL went high.
        if (r_state == BITS && w_readPhase && !r_bit[3] &&
            r_quarter == 2'd3 && r_qcnt == '0) begin
          w_rx = {r_rx[6:0], bus.sio_d_in};
        end
        if (w_slotEnd) begin
          case (r_state)
            START: begin
              w_state = BITS;
              w_bit   = 4'd0;
              w_byte  = 2'd0;
            end
            BITS: begin
              if (r_bit == 4'd8) begin
                w_bit = 4'd0;
                if (r_byte == w_lastByte) begin
                  w_state = STOP;
                  w_byte  = 2'd0;
                end else begin
                  w_byte = r_byte + 2'd1;
                end
              end else begin
                w_bit = r_bit + 4'd1;
              end
            end
            default: begin
              w_state = DONE;
              w_ready = 1'b1;
              if (r_op == 4'd2) w_dataOut = r_rx;
            end
          endcase
        end
      end
      DONE: begin
        if (!bus.sccb_valid) begin
          w_ready = 1'b0;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_qcnt    <= '0;
      r_quarter <= 2'd0;
      r_bit     <= 4'd0;
      r_byte    <= 2'd0;
      r_op      <= 4'd0;
      r_addr    <= 7'd0;
      r_reg     <= 8'd0;
      r_data    <= 8'd0;
      r_rx      <= 8'd0;
      r_dataOut <= 8'd0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_qcnt    <= w_qcnt;
      r_quarter <= w_quarter;
      r_bit     <= w_bit;
      r_byte    <= w_byte;
      r_op      <= w_op;
      r_addr    <= w_addr;
      r_reg     <= w_reg;
      r_data    <= w_data;
      r_rx      <= w_rx;
      r_dataOut <= w_dataOut;
      r_ready   <= w_ready;
    end
  end

  // Line levels are a pure function of slot type and quarter; idle is both lines high and driven.
  always_comb begin
    w_scl    = 1'b1;
    w_sdaOut = 1'b1;
    w_sdaOe  = 1'b1;
    case (r_state)
      START: begin
        w_scl    = (r_quarter != 2'd3);
        w_sdaOut = (r_quarter < 2'd2);
      end
      BITS: begin
        w_scl    = r_quarter[1];
        w_sdaOut = w_bitVal;
        w_sdaOe  = r_bit[3] ? w_readPhase : !w_readPhase;
      end
      STOP: begin
        w_scl    = (r_quarter != 2'd0);
        w_sdaOut = r_quarter[1];
      end
      default: ;
    endcase
  end

  assign bus.SIO_C         = w_scl;
  assign bus.sio_d_out     = w_sdaOut;
  assign bus.sio_d_oe      = w_sdaOe;
  assign bus.sccb_ready    = r_ready;
  assign bus.sccb_DATA_OUT = r_dataOut;

endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: a line-level bus monitor/slave decodes the wire traffic into
// bytes and compares them, plus latency and handshake behaviour, with a transaction model.
module tb_sccb_master;
  localparam int DIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sccb_master_if bus();
  sccb_master #(.CLK_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] capByte[$];
  logic       capNinth[$];
  logic [8:0] capOe[$];
  int         monBits = 0;
  int         sclEdges = 0;
  int         stopCount = 0;
  logic       prevC = 1'b1;
  logic       prevD = 1'b1;
  logic       slaveDrive = 1'b1;
  logic       pad;
  logic [7:0] monShift = 8'd0;
  logic [7:0] monOe = 8'd0;
  logic [7:0] slaveByte = 8'd0;
  logic [7:0] lastRead = 8'd0;

  assign bus.sio_d_in = slaveDrive;

  // Open-drain style pad model: watches SCL/SDA edges like a real slave would.
  always @(negedge clk) begin
    logic [7:0] firstByte;
    int pos;
    pad = bus.sio_d_oe ? bus.sio_d_out : slaveDrive;
    if (rst) begin
      monBits    = 0;
      prevC      = 1'b1;
      prevD      = 1'b1;
      slaveDrive = 1'b1;
    end else begin
      if (bus.SIO_C != prevC) sclEdges++;
      if (bus.SIO_C && prevC && prevD && !pad) begin
        monBits    = 0;
        slaveDrive = 1'b1;
      end else if (bus.SIO_C && prevC && !prevD && pad) begin
        stopCount++;
        monBits = 0;
      end else if (!prevC && bus.SIO_C) begin
        pos = monBits % 9;
        if (pos < 8) begin
          monShift = {monShift[6:0], pad};
          monOe    = {monOe[6:0], bus.sio_d_oe};
        end else begin
          capByte.push_back(monShift);
          capNinth.push_back(pad);
          capOe.push_back({monOe, bus.sio_d_oe});
        end
        monBits++;
      end else if (prevC && !bus.SIO_C) begin
        slaveDrive = 1'b1;
        if (capByte.size() >= 1 && monBits >= 9 && monBits < 17) begin
          firstByte = capByte[0];
          if (firstByte[0]) slaveDrive = slaveByte[3'(16 - monBits)];
        end
      end
      prevC = bus.SIO_C;
      prevD = pad;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One complete request: handshake, wire-level byte check, latency and ready protocol.
  task automatic applyStimulus(input logic [3:0] op, input logic [6:0] addr,
                               input logic [7:0] regv, input logic [7:0] data,
                               input logic [7:0] slv, input int hold, input bit scramble);
    logic [7:0] expB[$];
    int nb, expLat, acceptCyc, waited;
    expB.delete();
    nb = 0;
    if (op == 4'd0) begin
      expB = '{{addr, 1'b0}, regv, data};
      nb   = 3;
    end else if (op == 4'd1) begin
      expB = '{{addr, 1'b0}, regv};
      nb   = 2;
    end else if (op == 4'd2) begin
      expB = '{{addr, 1'b1}, slv};
      nb   = 2;
    end
    expLat = (nb > 0) ? (2 + 9 * nb) * 4 * DIV + 1 : 1;

    @(negedge clk);
    capByte.delete();
    capNinth.delete();
    capOe.delete();
    sclEdges  = 0;
    stopCount = 0;
    slaveByte = slv;
    bus.sccb_op_type = op;
    bus.sccb_addr    = addr;
    bus.sccb_REG     = regv;
    bus.sccb_DATA_IN = data;
    bus.sccb_valid   = 1'b1;
    acceptCyc = cyc;
    @(negedge clk);
    if (scramble) begin
      bus.sccb_op_type = 4'($urandom);
      bus.sccb_addr    = 7'($urandom);
      bus.sccb_REG     = 8'($urandom);
      bus.sccb_DATA_IN = 8'($urandom);
    end
    waited = 0;
    while (!bus.sccb_ready && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("latency", cyc - acceptCyc, expLat);
    checkOutput("byteCount", capByte.size(), nb);
    checkOutput("stopCount", stopCount, (nb > 0) ? 1 : 0);
    if (nb == 0) checkOutput("sclIdle", sclEdges, 0);
    for (int i = 0; i < nb && i < capByte.size(); i++) begin
      checkOutput($sformatf("byte%0d", i), capByte[i], expB[i]);
      checkOutput($sformatf("oe%0d", i), capOe[i],
                  (op == 4'd2 && i == 1) ? 9'h001 : 9'h1FE);
    end
    if (op == 4'd2 && capNinth.size() == 2) checkOutput("naBit", capNinth[1], 1);
    if (op == 4'd2) lastRead = slv;
    checkOutput("dataOut", bus.sccb_DATA_OUT, lastRead);
    for (int i = 0; i < hold; i++) @(negedge clk);
    if (hold > 0) checkOutput("readyHold", bus.sccb_ready, 1);
    bus.sccb_valid = 1'b0;
    @(negedge clk);
    checkOutput("readyDrop", bus.sccb_ready, 0);
  endtask

  initial begin
    int waited;
    logic [3:0] op;
    bus.sccb_valid   = 1'b0;
    bus.sccb_op_type = 4'd0;
    bus.sccb_addr    = 7'd0;
    bus.sccb_REG     = 8'd0;
    bus.sccb_DATA_IN = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstReady", bus.sccb_ready, 0);
    checkOutput("rstDataOut", bus.sccb_DATA_OUT, 0);
    checkOutput("rstScl", bus.SIO_C, 1);
    checkOutput("rstSda", bus.sio_d_out, 1);
    checkOutput("rstOe", bus.sio_d_oe, 1);
    rst = 1'b0;

    // Reference W3, then W2 followed by a read returning 0x76.
    applyStimulus(4'd0, 7'h21, 8'h12, 8'h80, 8'h00, 2, 1'b1);
    applyStimulus(4'd1, 7'h21, 8'h0A, 8'h55, 8'h00, 0, 1'b1);
    applyStimulus(4'd2, 7'h21, 8'h00, 8'h00, 8'h76, 1, 1'b1);

    // Long valid hold after ready, then an immediate follow-on request.
    applyStimulus(4'd1, 7'h3C, 8'hC3, 8'h00, 8'h00, 10, 1'b0);
    applyStimulus(4'd0, 7'h7F, 8'hFF, 8'h01, 8'h00, 0, 1'b0);

    // Illegal op code: no bus traffic.
    applyStimulus(4'd5, 7'h21, 8'h12, 8'h34, 8'h00, 1, 1'b0);

    // Reset while the REG byte is on the wire.
    @(negedge clk);
    bus.sccb_op_type = 4'd0;
    bus.sccb_addr    = 7'h55;
    bus.sccb_REG     = 8'hA5;
    bus.sccb_DATA_IN = 8'h3C;
    bus.sccb_valid   = 1'b1;
    waited = 0;
    while (monBits < 13 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midRegReached", (waited < 1000) ? 1 : 0, 1);
    rst = 1'b1;
    bus.sccb_valid = 1'b0;
    @(negedge clk);
    checkOutput("abortScl", bus.SIO_C, 1);
    checkOutput("abortSda", bus.sio_d_out, 1);
    checkOutput("abortOe", bus.sio_d_oe, 1);
    checkOutput("abortReady", bus.sccb_ready, 0);
    checkOutput("abortDataOut", bus.sccb_DATA_OUT, 0);
    rst = 1'b0;
    lastRead = 8'd0;
    applyStimulus(4'd0, 7'h55, 8'hA5, 8'h3C, 8'h00, 0, 1'b1);

    // Randomised mix of all op codes including illegal ones.
    for (int n = 0; n < 12; n++) begin
      op = 4'($urandom_range(0, 3));
      if (op == 4'd3) op = 4'($urandom_range(3, 15));
      applyStimulus(op, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
